// File: rtl/gbt_link_supervisor.sv
//------------------------------------------------------------------------------
// gbt_link_supervisor
//
// Reset/bring-up sequencer for one GBT bank in the 40 MHz frame-clock domain.
// Drives the MGT and GBT TX/RX resets in order and waits for each ready stage
// with a timeout. Timeouts are retried up to a limit, after which the block
// parks in FAULT. SFP loss of signal and link loss are monitored, and the link
// is re-sequenced automatically. State and counters are exported for status.
//
// Optional feature macro: GBT_LINK_SUPERVISOR_UPTIME_EN
//   defined     : uptime_o counts cycles spent in the current LINK_UP
//   not defined : uptime_o is tied to zero
//
// Ports
//   clk              in   1   frame clock
//   reset            in   1   synchronous, active-high
//   sfp_los_i        in   1   SFP loss of signal (async, 2FF-synchronised)
//   mgt_txready_i    in   1   MGT TX reset done (async, 2FF)
//   mgt_rxready_i    in   1   MGT RX reset done (async, 2FF)
//   gbt_tx_ready_i   in   1   GBT TX ready (async, 2FF)
//   gbt_rx_ready_i   in   1   GBT RX ready (async, 2FF)
//   link_ready_i     in   1   GBT link ready (async, 2FF)
//   force_reset_i    in   1   single-cycle restart request, synchronous to clk
//   mgt_txreset_o    out  1   MGT TX reset
//   mgt_rxreset_o    out  1   MGT RX reset
//   gbt_txreset_o    out  1   GBT TX reset
//   gbt_rxreset_o    out  1   GBT RX reset
//   link_up_o        out  1   high only in LINK_UP
//   fault_o          out  1   high only in FAULT
//   state_o          out  3   current state encoding
//   retry_cnt_o      out  8   timeouts since last success (saturating)
//   link_loss_cnt_o  out  16  link-loss events (saturating, cleared by reset)
//   uptime_o         out  32  cycles in the current LINK_UP
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module gbt_link_supervisor #(
   parameter int unsigned RESET_PULSE  = 16,
   parameter int unsigned MGT_TIMEOUT  = 4_000_000,
   parameter int unsigned LINK_TIMEOUT = 8_000_000,
   parameter int unsigned DEBOUNCE     = 1024,
   parameter int unsigned MAX_RETRIES  = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sfp_los_i,
   input  logic        mgt_txready_i,
   input  logic        mgt_rxready_i,
   input  logic        gbt_tx_ready_i,
   input  logic        gbt_rx_ready_i,
   input  logic        link_ready_i,
   input  logic        force_reset_i,
   output logic        mgt_txreset_o,
   output logic        mgt_rxreset_o,
   output logic        gbt_txreset_o,
   output logic        gbt_rxreset_o,
   output logic        link_up_o,
   output logic        fault_o,
   output logic [2:0]  state_o,
   output logic [7:0]  retry_cnt_o,
   output logic [15:0] link_loss_cnt_o,
   output logic [31:0] uptime_o
);

   // One shared state timer covers the reset pulse and both wait stages.
   localparam int unsigned TMR_MAX_A = (RESET_PULSE > MGT_TIMEOUT) ? RESET_PULSE : MGT_TIMEOUT;
   localparam int unsigned TMR_MAX   = (TMR_MAX_A > LINK_TIMEOUT) ? TMR_MAX_A : LINK_TIMEOUT;
   localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);
   localparam int unsigned DEB_W     = $clog2(DEBOUNCE + 1);
   localparam int unsigned SYNC_W    = 6;

   localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(RESET_PULSE - 1);
   localparam logic [TMR_W-1:0] MGT_LAST   = TMR_W'(MGT_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] LINK_LAST  = TMR_W'(LINK_TIMEOUT - 1);
   localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE - 1);
   localparam logic [7:0]       RETRY_LIM  = 8'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_RST_ASSERT = 3'd1,
      S_WAIT_MGT   = 3'd2,
      S_RST_GBT    = 3'd3,
      S_WAIT_LINK  = 3'd4,
      S_LINK_UP    = 3'd5,
      S_FAULT      = 3'd6
   } state_t;

   state_t              r_state;
   logic [TMR_W-1:0]    r_timer;
   logic [DEB_W-1:0]    r_deb;
   logic [7:0]          r_retry;
   logic [15:0]         r_loss_cnt;
   logic [SYNC_W-1:0]   r_sync1;
   logic [SYNC_W-1:0]   r_sync2;
   logic                r_mgt_txreset;
   logic                r_mgt_rxreset;
   logic                r_gbt_txreset;
   logic                r_gbt_rxreset;
   logic                r_link_up;
   logic                r_fault;

   logic [SYNC_W-1:0]   w_async_in;
   logic                w_los_s;
   logic                w_mgt_ready_s;
   logic                w_link_good_s;
   logic                w_link_ready_s;
   logic [7:0]          w_retry_inc;
   logic                w_retry_exhausted;

   //---------------------------------------------------------------------------
   // Two-flop synchroniser for the asynchronous status inputs
   //---------------------------------------------------------------------------
   assign w_async_in = {sfp_los_i, mgt_txready_i, mgt_rxready_i,
                        gbt_tx_ready_i, gbt_rx_ready_i, link_ready_i};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_async_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_los_s        = r_sync2[5];
   assign w_mgt_ready_s  = r_sync2[4] & r_sync2[3];
   assign w_link_good_s  = r_sync2[2] & r_sync2[1] & r_sync2[0];
   assign w_link_ready_s = r_sync2[0];

   // Saturating retry increment and the fault decision it drives
   assign w_retry_inc       = (r_retry == 8'hFF) ? 8'hFF : r_retry + 8'd1;
   assign w_retry_exhausted = (w_retry_inc >= RETRY_LIM);

   //---------------------------------------------------------------------------
   // Sequencer FSM with its timer, debounce and event counters.
   // Every transition clears the timer and debounce counter.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_timer    <= '0;
         r_deb      <= '0;
         r_retry    <= '0;
         r_loss_cnt <= '0;
      end else if (w_los_s && (r_state != S_FAULT)) begin
         // LOS wins over a restart request; retry history is preserved
         r_state <= S_IDLE;
         r_timer <= '0;
         r_deb   <= '0;
      end else if (force_reset_i) begin
         r_state <= S_RST_ASSERT;
         r_timer <= '0;
         r_deb   <= '0;
         r_retry <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // LOS is already known clear here
               r_state <= S_RST_ASSERT;
               r_timer <= '0;
               r_deb   <= '0;
            end

            S_RST_ASSERT: begin
               if (r_timer == PULSE_LAST) begin
                  r_state <= S_WAIT_MGT;
                  r_timer <= '0;
                  r_deb   <= '0;
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end

            S_WAIT_MGT: begin
               if (w_mgt_ready_s) begin
                  r_state <= S_RST_GBT;
                  r_timer <= '0;
                  r_deb   <= '0;
               end else if (r_timer == MGT_LAST) begin
                  r_retry <= w_retry_inc;
                  r_state <= w_retry_exhausted ? S_FAULT : S_RST_ASSERT;
                  r_timer <= '0;
                  r_deb   <= '0;
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end

            S_RST_GBT: begin
               r_state <= S_WAIT_LINK;
               r_timer <= '0;
               r_deb   <= '0;
            end

            S_WAIT_LINK: begin
               // Debounce completion takes precedence over a coincident timeout
               if (w_link_good_s && (r_deb == DEB_LAST)) begin
                  r_state <= S_LINK_UP;
                  r_retry <= '0;
                  r_timer <= '0;
                  r_deb   <= '0;
               end else if (r_timer == LINK_LAST) begin
                  r_retry <= w_retry_inc;
                  r_state <= w_retry_exhausted ? S_FAULT : S_RST_ASSERT;
                  r_timer <= '0;
                  r_deb   <= '0;
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
                  r_deb   <= w_link_good_s ? r_deb + DEB_W'(1) : '0;
               end
            end

            S_LINK_UP: begin
               // Only a sustained drop of link_ready counts as a loss
               if (!w_link_ready_s) begin
                  if (r_deb == DEB_LAST) begin
                     r_state <= S_RST_ASSERT;
                     r_timer <= '0;
                     r_deb   <= '0;
                     if (r_loss_cnt != 16'hFFFF) begin
                        r_loss_cnt <= r_loss_cnt + 16'd1;
                     end
                  end else begin
                     r_deb <= r_deb + DEB_W'(1);
                  end
               end else begin
                  r_deb <= '0;
               end
            end

            S_FAULT: begin
               r_state <= S_FAULT;
            end

            default: begin
               r_state <= S_IDLE;
               r_timer <= '0;
               r_deb   <= '0;
            end
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Registered output decode; follows the state register by one cycle
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mgt_txreset <= 1'b1;
         r_mgt_rxreset <= 1'b1;
         r_gbt_txreset <= 1'b1;
         r_gbt_rxreset <= 1'b1;
         r_link_up     <= 1'b0;
         r_fault       <= 1'b0;
      end else begin
         case (r_state)
            S_WAIT_MGT: begin
               r_mgt_txreset <= 1'b0;
               r_mgt_rxreset <= 1'b0;
               r_gbt_txreset <= 1'b1;
               r_gbt_rxreset <= 1'b1;
            end
            S_RST_GBT, S_WAIT_LINK, S_LINK_UP: begin
               r_mgt_txreset <= 1'b0;
               r_mgt_rxreset <= 1'b0;
               r_gbt_txreset <= 1'b0;
               r_gbt_rxreset <= 1'b0;
            end
            default: begin
               r_mgt_txreset <= 1'b1;
               r_mgt_rxreset <= 1'b1;
               r_gbt_txreset <= 1'b1;
               r_gbt_rxreset <= 1'b1;
            end
         endcase
         r_link_up <= (r_state == S_LINK_UP);
         r_fault   <= (r_state == S_FAULT);
      end
   end

   assign mgt_txreset_o   = r_mgt_txreset;
   assign mgt_rxreset_o   = r_mgt_rxreset;
   assign gbt_txreset_o   = r_gbt_txreset;
   assign gbt_rxreset_o   = r_gbt_rxreset;
   assign link_up_o       = r_link_up;
   assign fault_o         = r_fault;
   assign state_o         = r_state;
   assign retry_cnt_o     = r_retry;
   assign link_loss_cnt_o = r_loss_cnt;

`ifdef GBT_LINK_SUPERVISOR_UPTIME_EN
   //---------------------------------------------------------------------------
   // Uptime: restarts at 1 on the first LINK_UP cycle, holds after leaving
   //---------------------------------------------------------------------------
   logic [31:0] r_uptime;
   logic        r_was_up;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_uptime <= '0;
         r_was_up <= 1'b0;
      end else begin
         r_was_up <= (r_state == S_LINK_UP);
         if (r_state == S_LINK_UP) begin
            if (!r_was_up) begin
               r_uptime <= 32'd1;
            end else if (r_uptime != 32'hFFFF_FFFF) begin
               r_uptime <= r_uptime + 32'd1;
            end
         end
      end
   end

   assign uptime_o = r_uptime;
`else
   assign uptime_o = '0;
`endif

endmodule
